// File: rtl/if_id_buf_if.sv
// Fetch/decode bundle for if_id_buf: fetch-side handshake and decode-side fields.
// BubbleCnt/FlushCnt exist only when IFID_STATS_EN is defined.
interface if_id_buf_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              FetchValid;
  logic [ADDR_W-1:0] PcAddr4;
  logic [15:0]       InsOut;
  logic              FetchReady;
  logic              IfIdRst;
  logic              DecStall;
  logic              IdValid;
  logic [ADDR_W-1:0] PcAddr0;
  logic [4:0]        OP;
  logic [2:0]        RegIn1;
  logic [2:0]        RegIn2;
  logic [2:0]        RegIn3;
  logic [4:0]        LastOp;
  logic [10:0]       Src;
  logic [CW-1:0]     Count;
`ifdef IFID_STATS_EN
  logic [15:0]       BubbleCnt;
  logic [15:0]       FlushCnt;
`endif

  // master is the surrounding pipeline (fetch + decode), slave is the buffer
  modport master (
    output FetchValid, PcAddr4, InsOut, IfIdRst, DecStall,
    input  FetchReady, IdValid, PcAddr0, OP, RegIn1, RegIn2, RegIn3, LastOp, Src, Count
`ifdef IFID_STATS_EN
    , input BubbleCnt, FlushCnt
`endif
  );

  modport slave (
    input  FetchValid, PcAddr4, InsOut, IfIdRst, DecStall,
    output FetchReady, IdValid, PcAddr0, OP, RegIn1, RegIn2, RegIn3, LastOp, Src, Count
`ifdef IFID_STATS_EN
    , output BubbleCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/if_id_buf.sv
// IF/ID stage: DEPTH-entry instruction queue feeding a registered decode-field output.
// Define IFID_STATS_EN to add the BubbleCnt/FlushCnt counters.
module if_id_buf #(
  parameter int         ADDR_W = 16,
  parameter int         DEPTH  = 4,
  parameter logic [4:0] NOP_OP = 5'h00
) (
  input logic        Clk,
  input logic        Rst,
  if_id_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] BUBBLE_INS = {NOP_OP, 11'b0};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("if_id_buf: DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W+15:0] mem [DEPTH];
  logic [PW-1:0]      head_reg, tail_reg;
  logic [CW-1:0]      count_reg;
  logic               id_valid_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [15:0]        ins_reg;

  logic fetch_ready, queue_empty, push, advance, pop, write_through, enqueue;

  assign fetch_ready   = (count_reg != CW'(DEPTH));
  assign queue_empty   = (count_reg == '0);
  assign push          = bus.FetchValid && fetch_ready && !bus.IfIdRst;
  assign advance       = !id_valid_reg || !bus.DecStall;
  assign pop           = advance && !queue_empty && !bus.IfIdRst;
  // An empty queue with a free output register bypasses storage entirely
  assign write_through = push && advance && queue_empty;
  assign enqueue       = push && !write_through;

  // Storage is left unreset so it can map onto distributed/block RAM
  always_ff @(posedge Clk) begin
    if (enqueue)
      mem[tail_reg] <= {bus.PcAddr4, bus.InsOut};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (bus.IfIdRst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enqueue)
        tail_reg <= tail_reg + 1'b1;
      if (pop)
        head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CW'(enqueue) - CW'(pop);
    end
  end

  // Output register holds the raw instruction; decode fields are slices of it
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      id_valid_reg <= 1'b0;
      pc_reg       <= '0;
      ins_reg      <= BUBBLE_INS;
    end else if (bus.IfIdRst) begin
      id_valid_reg <= 1'b0;
      pc_reg       <= bus.PcAddr4;
      ins_reg      <= BUBBLE_INS;
    end else if (advance) begin
      if (!queue_empty) begin
        id_valid_reg      <= 1'b1;
        {pc_reg, ins_reg} <= mem[head_reg];
      end else if (push) begin
        id_valid_reg <= 1'b1;
        pc_reg       <= bus.PcAddr4;
        ins_reg      <= bus.InsOut;
      end else begin
        id_valid_reg <= 1'b0;
        ins_reg      <= BUBBLE_INS;
      end
    end
  end

  assign bus.FetchReady = fetch_ready;
  assign bus.Count      = count_reg;
  assign bus.IdValid    = id_valid_reg;
  assign bus.PcAddr0    = pc_reg;
  assign bus.OP         = ins_reg[15:11];
  assign bus.RegIn1     = ins_reg[10:8];
  assign bus.RegIn2     = ins_reg[7:5];
  assign bus.RegIn3     = ins_reg[4:2];
  assign bus.LastOp     = ins_reg[4:0];
  assign bus.Src        = ins_reg[10:0];

`ifdef IFID_STATS_EN
  logic [15:0] bubble_cnt_reg, flush_cnt_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bubble_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      if (bus.IfIdRst)
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      else if (advance && queue_empty && !push)
        bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
    end
  end

  assign bus.BubbleCnt = bubble_cnt_reg;
  assign bus.FlushCnt  = flush_cnt_reg;
`endif
endmodule
